// File: rtl/arrow_sequencer.sv
// Rhythm-game arrow sequencer: count-in, LFSR-driven arrow beats, hit scoring and streak tracking.
// Define ARROW_SEQ_DOUBLE_EN to enable double-arrow codes; the default build produces single arrows and rests only.
module arrow_sequencer #(
    parameter int          BEAT_CYCLES   = 50_000_000,
    parameter int          WINDOW_CYCLES = 25_000_000,
    parameter int          COUNT_BEATS   = 4,
    parameter int          NUM_BEATS     = 64,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        correctHit,
    input  logic        incorrectHit,
    output logic        metronome_clk,
    output logic [3:0]  arrow,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo,
    output logic [7:0]  beat_idx,
    output logic        done
);

    localparam int CNT_W = $clog2(BEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_WIN  = CNT_W'(WINDOW_CYCLES);
    localparam logic [31:0] COUNTIN_LAST  = 32'(COUNT_BEATS - 1);
    localparam logic [31:0] PLAY_LAST     = 32'(NUM_BEATS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COUNTIN = 2'd1;
    localparam logic [1:0] S_PLAY    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_beatCnt;
    logic [15:0]      r_lfsr;
    logic             r_metronome;
    logic [3:0]       r_arrow;
    logic [15:0]      r_score;
    logic [7:0]       r_combo;
    logic [7:0]       r_maxCombo;
    logic [7:0]       r_beatIdx;
    logic             r_done;

    logic [1:0]       w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic [31:0]      w_beatNext;
    logic             w_beatEnd;
    logic             w_restart;
    logic [15:0]      w_lfsrNext;
    logic [3:0]       w_arrowMap;
    logic [7:0]       w_comboInc;

    assign w_beatEnd  = (r_cnt == CNT_LAST);
    assign w_restart  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_lfsrNext = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_comboInc = (r_combo == 8'hFF) ? 8'hFF : r_combo + 8'd1;

    // Arrow code derived from the freshly advanced LFSR value.
    always_comb begin
        w_arrowMap = 4'd0;
`ifdef ARROW_SEQ_DOUBLE_EN
        if (w_lfsrNext[3:0] <= 4'd10) begin
            w_arrowMap = w_lfsrNext[3:0];
        end else begin
            w_arrowMap = w_lfsrNext[3:0] - 4'd5;
        end
`else
        if (w_lfsrNext[3:2] == 2'b11) begin
            w_arrowMap = 4'd0;
        end else begin
            w_arrowMap = {2'b00, w_lfsrNext[1:0]} + 4'd1;
        end
`endif
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_beatNext  = r_beatCnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_stateNext = S_COUNTIN;
                    w_cntNext   = '0;
                    w_beatNext  = '0;
                end
            end
            S_COUNTIN: begin
                if (w_beatEnd) begin
                    w_cntNext = '0;
                    if (r_beatCnt == COUNTIN_LAST) begin
                        w_stateNext = S_PLAY;
                        w_beatNext  = '0;
                    end else begin
                        w_beatNext = r_beatCnt + 32'd1;
                    end
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            S_PLAY: begin
                if (w_beatEnd) begin
                    w_cntNext = '0;
                    if (r_beatCnt == PLAY_LAST) begin
                        w_stateNext = S_DONE;
                        w_beatNext  = '0;
                    end else begin
                        w_beatNext = r_beatCnt + 32'd1;
                    end
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Outputs are computed from next-state values so arrow and the window rise share one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_beatCnt   <= '0;
            r_lfsr      <= SEED;
            r_metronome <= 1'b0;
            r_arrow     <= 4'd0;
            r_score     <= 16'd0;
            r_combo     <= 8'd0;
            r_maxCombo  <= 8'd0;
            r_beatIdx   <= 8'd0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_beatCnt   <= w_beatNext;
            r_metronome <= ((w_stateNext == S_COUNTIN) || (w_stateNext == S_PLAY))
                           && (w_cntNext < CNT_WIN);
            r_done      <= (w_stateNext == S_DONE);
            if (w_restart) begin
                r_lfsr     <= SEED;
                r_arrow    <= 4'd0;
                r_score    <= 16'd0;
                r_combo    <= 8'd0;
                r_maxCombo <= 8'd0;
                r_beatIdx  <= 8'd0;
            end else begin
                if ((w_stateNext == S_PLAY) && (w_cntNext == '0)) begin
                    r_lfsr  <= w_lfsrNext;
                    r_arrow <= w_arrowMap;
                end else if (w_stateNext != S_PLAY) begin
                    r_arrow <= 4'd0;
                end
                // Rest beats advance the index but leave score and streak alone.
                if ((r_state == S_PLAY) && w_beatEnd) begin
                    r_beatIdx <= r_beatIdx + 8'd1;
                    if (r_arrow != 4'd0) begin
                        if (correctHit && !incorrectHit) begin
                            r_score <= (r_score == 16'hFFFF) ? 16'hFFFF : r_score + 16'd1;
                            r_combo <= w_comboInc;
                            if (w_comboInc > r_maxCombo) begin
                                r_maxCombo <= w_comboInc;
                            end
                        end else begin
                            r_combo <= 8'd0;
                        end
                    end
                end
            end
        end
    end

    assign metronome_clk = r_metronome;
    assign arrow         = r_arrow;
    assign score         = r_score;
    assign combo         = r_combo;
    assign max_combo     = r_maxCombo;
    assign beat_idx      = r_beatIdx;
    assign done          = r_done;

endmodule

// File: tb/tb_arrow_sequencer.sv
// Scoreboard bench for arrow_sequencer with a short beat so whole songs fit in a few hundred cycles.
module tb_arrow_sequencer;

    localparam int          BEAT = 16;
    localparam int          WIN  = 8;
    localparam int          CIN  = 2;
    localparam int          NB   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic [15:0] score;
        logic [7:0]  combo;
        logic [7:0]  maxc;
        logic [7:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        correctHit;
    logic        incorrectHit;
    logic        metronome_clk;
    logic [3:0]  arrow;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [7:0]  beat_idx;
    logic        done;

    int checkCount = 0;
    int errorCount = 0;

    exp_t        sbQ[$];
    logic [15:0] mLfsr;
    logic [15:0] mScore;
    logic [7:0]  mCombo;
    logic [7:0]  mMax;
    logic [7:0]  mIdx;
    logic [3:0]  mArrow;

    always #5 clk = ~clk;

    arrow_sequencer #(
        .BEAT_CYCLES(BEAT), .WINDOW_CYCLES(WIN), .COUNT_BEATS(CIN),
        .NUM_BEATS(NB), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .correctHit(correctHit), .incorrectHit(incorrectHit),
        .metronome_clk(metronome_clk), .arrow(arrow), .score(score),
        .combo(combo), .max_combo(max_combo), .beat_idx(beat_idx), .done(done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [3:0] mapArrow(input logic [15:0] v);
`ifdef ARROW_SEQ_DOUBLE_EN
        return (v[3:0] <= 4'd10) ? v[3:0] : v[3:0] - 4'd5;
`else
        return (v[3:2] == 2'b11) ? 4'd0 : {2'b00, v[1:0]} + 4'd1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic i);
        correctHit   = c;
        incorrectHit = i;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "Metro"}, {31'd0, metronome_clk}, 32'd0);
        checkOutput({tag, "Arrow"}, {28'd0, arrow}, 32'd0);
        checkOutput({tag, "Idx"}, {24'd0, beat_idx}, 32'd0);
        checkOutput({tag, "Done"}, {31'd0, done}, 32'd0);
    endtask

    // mode 0: always correct; mode 1: double verdict on beat 1 plus start during play; mode 2: random
    task automatic runSong(input int mode);
        exp_t e;
        logic c;
        logic i;
        start = 1'b1;
        tick();
        start = 1'b0;
        mLfsr = SEED; mScore = 0; mCombo = 0; mMax = 0; mIdx = 0;
        checkOutput("restartScore", {16'd0, score}, 32'd0);
        checkOutput("restartMax", {24'd0, max_combo}, 32'd0);
        for (int cyc = 0; cyc < CIN * BEAT; cyc++) begin
            checkOutput("cinMetro", {31'd0, metronome_clk}, ((cyc % BEAT) < WIN) ? 32'd1 : 32'd0);
            checkOutput("cinArrow", {28'd0, arrow}, 32'd0);
            checkOutput("cinDone", {31'd0, done}, 32'd0);
            if (mode == 2) applyStimulus(1'($urandom), 1'($urandom));
            tick();
        end
        for (int b = 0; b < NB; b++) begin
            mLfsr  = lfsrStep(mLfsr);
            mArrow = mapArrow(mLfsr);
            for (int cyc = 0; cyc < BEAT; cyc++) begin
                checkOutput("playArrow", {28'd0, arrow}, {28'd0, mArrow});
                checkOutput("playMetro", {31'd0, metronome_clk}, (cyc < WIN) ? 32'd1 : 32'd0);
                checkOutput("playIdx", {24'd0, beat_idx}, {24'd0, mIdx});
`ifndef ARROW_SEQ_DOUBLE_EN
                if (cyc == 0) checkOutput("arrowRange", {31'd0, arrow <= 4'd4}, 32'd1);
`endif
                start = (mode == 1) && (b == 0) && (cyc == 5);
                if (cyc == BEAT - 1) begin
                    if (mode == 2) begin
                        c = 1'($urandom);
                        i = 1'($urandom);
                    end else begin
                        c = 1'b1;
                        i = (mode == 1) && (b == 1);
                    end
                    applyStimulus(c, i);
                    if (mArrow != 4'd0) begin
                        if (c && !i) begin
                            mScore = (mScore == 16'hFFFF) ? 16'hFFFF : mScore + 16'd1;
                            mCombo = (mCombo == 8'hFF) ? 8'hFF : mCombo + 8'd1;
                            if (mCombo > mMax) mMax = mCombo;
                        end else begin
                            mCombo = 8'd0;
                        end
                    end
                    mIdx = mIdx + 8'd1;
                    sbQ.push_back('{score: mScore, combo: mCombo, maxc: mMax, idx: mIdx});
                end else if (mode == 2) begin
                    applyStimulus(1'($urandom), 1'($urandom));
                end else begin
                    applyStimulus(mode == 0, 1'b0);
                end
                tick();
                start = 1'b0;
                if (cyc == BEAT - 1) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("sbEmpty", 32'd0, 32'd1);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("score", {16'd0, score}, {16'd0, e.score});
                        checkOutput("combo", {24'd0, combo}, {24'd0, e.combo});
                        checkOutput("maxCombo", {24'd0, max_combo}, {24'd0, e.maxc});
                        checkOutput("beatIdx", {24'd0, beat_idx}, {24'd0, e.idx});
                    end
                end
            end
        end
        applyStimulus(1'b0, 1'b0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            checkOutput("doneFlag", {31'd0, done}, 32'd1);
            checkOutput("doneMetro", {31'd0, metronome_clk}, 32'd0);
            checkOutput("doneArrow", {28'd0, arrow}, 32'd0);
            checkOutput("doneScore", {16'd0, score}, {16'd0, mScore});
            checkOutput("doneCombo", {24'd0, combo}, {24'd0, mCombo});
            checkOutput("doneIdx", {24'd0, beat_idx}, NB);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #12;
        checkQuiet("reset");
        checkOutput("resetScore", {16'd0, score}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkQuiet("idle");
        end
        checkOutput("firstArrowModel", {28'd0, mapArrow(lfsrStep(SEED))}, {28'd0, mapArrow(16'h59C3)});

        runSong(0);
        runSong(1);

        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < CIN * BEAT + BEAT + 4; k++) tick();
        #3 rst_n = 1'b0;
        #1;
        checkQuiet("asyncRst");
        checkOutput("asyncRstScore", {16'd0, score}, 32'd0);
        checkOutput("asyncRstCombo", {24'd0, combo}, 32'd0);
        checkOutput("asyncRstMax", {24'd0, max_combo}, 32'd0);
        #2 rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick();
            checkQuiet("postRst");
        end

        runSong(2);
        runSong(2);
        runSong(0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
